// File: rtl/io_event_arbiter_if.sv
// ----------------------------------------------------------------------------
// io_event_arbiter_if
// Bundles the user-input event pulses, the CPU-side event queue read port and
// the dropped-event counter of io_event_arbiter.
//   master : event sources + CPU reader (drives pulses, ev_ready, clr_drops)
//   slave  : the arbiter itself (drives ev_valid, ev_code, ev_count, drop_count)
// Signals:
//   compass_pulse[4:0] one-cycle pulses; bit0 C, 1 E, 2 N, 3 S, 4 W
//   rotary_push        one-cycle pulse, rotary push button
//   rotary_event       one-cycle pulse, rotary step
//   rotary_left        step direction, qualified by rotary_event (1 = left)
//   ev_valid           queue non-empty, ev_code valid
//   ev_ready           CPU pop strobe (pop on ev_valid && ev_ready)
//   ev_code[2:0]       event code at queue head
//   ev_count           entries currently queued
//   drop_count         events lost since reset / last clear (saturating)
//   clr_drops          one-cycle pulse, zeroes drop_count
// ----------------------------------------------------------------------------
interface io_event_arbiter_if #(
    parameter int FIFO_DEPTH     = 8,
    parameter int DROP_CNT_WIDTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [4:0]                compass_pulse;
    logic                      rotary_push;
    logic                      rotary_event;
    logic                      rotary_left;
    logic                      ev_valid;
    logic                      ev_ready;
    logic [2:0]                ev_code;
    logic [CNT_W-1:0]          ev_count;
    logic [DROP_CNT_WIDTH-1:0] drop_count;
    logic                      clr_drops;

    modport master (
        output compass_pulse, rotary_push, rotary_event, rotary_left,
        output ev_ready, clr_drops,
        input  ev_valid, ev_code, ev_count, drop_count
    );

    modport slave (
        input  compass_pulse, rotary_push, rotary_event, rotary_left,
        input  ev_ready, clr_drops,
        output ev_valid, ev_code, ev_count, drop_count
    );
endinterface

// File: rtl/io_event_arbiter.sv
// ----------------------------------------------------------------------------
// io_event_arbiter
// Merges single-cycle user-input pulses (5 compass buttons, rotary push,
// rotary step) into one ordered event queue read by the CPU over MMIO.
// Each source has a pending latch; a round-robin arbiter moves at most one
// pending event per cycle into a show-ahead FIFO.
// Ports:
//   clk    in  CPU clock
//   rst    in  synchronous active-high reset
//   ev_if  slave modport of io_event_arbiter_if (pulses in, queue/drop out)
// Event codes: 0 C, 1 E, 2 N, 3 S, 4 W, 5 push, 6 rotary right, 7 rotary left.
// Source indices: 0-4 compass, 5 rotary push, 6 rotary step.
// ----------------------------------------------------------------------------
module io_event_arbiter #(
    parameter int FIFO_DEPTH     = 8,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    io_event_arbiter_if.slave ev_if
);
    localparam int NSRC  = 7;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int SUM_W = DROP_CNT_WIDTH + 4;

    localparam logic [AW:0]               PTR_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]             IDX_ONE  = AW'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;
    localparam logic [2:0]                RR_RESET = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NSRC-1:0]           pend_q, pend_d;
    logic                      dir_q, dir_d;       // latched rotary direction
    logic [2:0]                rr_q, rr_d;         // last granted source
    logic [AW:0]               wr_ptr_q, rd_ptr_q; // extra bit tells full from empty
    logic [2:0]                mem_q [FIFO_DEPTH];
    logic [2:0]                head_q, head_d;     // registered queue head
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [NSRC-1:0]  pulse;
    logic [NSRC-1:0]  gnt_vec;
    logic [NSRC-1:0]  drop_vec;
    logic             gnt_found;
    logic [2:0]       gnt_idx;
    logic             grant;
    logic [2:0]       wr_code;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             pop;
    logic [AW-1:0]    rd_next;
    logic [2:0]       n_drop;
    logic [SUM_W-1:0] drop_sum;

    assign pulse = {ev_if.rotary_event, ev_if.rotary_push, ev_if.compass_pulse};

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    // Full is judged on this cycle's occupancy, before any pop lands.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = !empty && ev_if.ev_ready;
    assign rd_next = rd_ptr_q[AW-1:0] + IDX_ONE;

    // Round-robin search: first pending source strictly after rr_q, wrapping 6->0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        for (int k = 1; k <= NSRC; k++) begin
            if (!gnt_found && pend_q[(int'(rr_q) + k) % NSRC]) begin
                gnt_found = 1'b1;
                gnt_idx   = 3'((int'(rr_q) + k) % NSRC);
            end
        end
    end

    assign grant   = gnt_found && !full;
    assign wr_code = (gnt_idx == 3'd6) ? (dir_q ? 3'd7 : 3'd6) : gnt_idx;
    assign rr_d    = grant ? gnt_idx : rr_q;

    // Per-source latch update. A pulse on a granted source re-arms the latch
    // with the new event; a pulse on a pending, ungranted source is a drop.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        assign gnt_vec[gi]  = grant && (gnt_idx == 3'(gi));
        assign drop_vec[gi] = pulse[gi] && pend_q[gi] && !gnt_vec[gi];
        assign pend_d[gi]   = pulse[gi] || (pend_q[gi] && !gnt_vec[gi]);
    end

    // Direction only follows a pulse that is actually accepted.
    assign dir_d = (pulse[6] && (!pend_q[6] || gnt_vec[6])) ? ev_if.rotary_left : dir_q;

    always_comb begin
        n_drop = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            n_drop = n_drop + {2'b00, drop_vec[i]};
        end
    end

    assign drop_sum = SUM_W'(drop_q) + SUM_W'(n_drop);

    always_comb begin
        if (ev_if.clr_drops) begin
            drop_d = '0;  // clear wins over same-cycle drops
        end else if (drop_sum > SUM_W'(DROP_MAX)) begin
            drop_d = DROP_MAX;
        end else begin
            drop_d = drop_sum[DROP_CNT_WIDTH-1:0];
        end
    end

    // Show-ahead head: keep head_q equal to the entry the reader sees next.
    // When the queue becomes empty the last head value is simply held.
    always_comb begin
        head_d = head_q;
        if (empty) begin
            if (grant) begin
                head_d = wr_code;
            end
        end else if (pop) begin
            if (count >= CNT_W'(2)) begin
                head_d = mem_q[rd_next];
            end else if (grant) begin
                head_d = wr_code;  // sole entry popped, new one becomes head
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            dir_q    <= 1'b0;
            rr_q     <= RR_RESET;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= 3'd0;
            drop_q   <= '0;
        end else begin
            pend_q <= pend_d;
            dir_q  <= dir_d;
            rr_q   <= rr_d;
            head_q <= head_d;
            drop_q <= drop_d;
            if (grant) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage array kept free of reset so it maps onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (grant && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_code;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ev_if.ev_valid   = !empty;
    assign ev_if.ev_code    = head_q;
    assign ev_if.ev_count   = count;
    assign ev_if.drop_count = drop_q;
endmodule

// File: tb/tb_io_event_arbiter.sv
module tb_io_event_arbiter;
    localparam int DEPTH    = 8;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_event_arbiter_if #(.FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(DROP_W)) bus ();

    io_event_arbiter #(.FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(DROP_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .ev_if (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model: queue + pending flags ----------------
    bit m_pend[7];
    bit m_dir;
    int m_rr;
    int m_q[$];
    int m_drop;

    function automatic void model_step(input logic [4:0] cp, input bit push, evt, left,
                                       input bit rdy, clr, r);
        bit p[7];
        int g;
        int nd;
        int code;
        bit popped;
        if (r) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_dir = 1'b0; m_rr = 6; m_q.delete(); m_drop = 0;
            return;
        end
        for (int i = 0; i < 5; i++) p[i] = cp[i];
        p[5] = push; p[6] = evt;
        popped = rdy && (m_q.size() > 0);
        g = -1;
        if (m_q.size() < DEPTH)
            for (int k = 1; k <= 7; k++)
                if (g < 0 && m_pend[(m_rr + k) % 7]) g = (m_rr + k) % 7;
        code = (g == 6) ? (m_dir ? 7 : 6) : g;
        nd = 0;
        for (int i = 0; i < 7; i++) if (p[i] && m_pend[i] && g != i) nd++;
        for (int i = 0; i < 7; i++) begin
            if (p[i] && (!m_pend[i] || g == i)) begin
                m_pend[i] = 1'b1;
                if (i == 6) m_dir = left;
            end else if (g == i) begin
                m_pend[i] = 1'b0;
            end
        end
        if (popped) void'(m_q.pop_front());
        if (g >= 0) begin m_q.push_back(code); m_rr = g; end
        if (clr) m_drop = 0;
        else m_drop = (m_drop + nd > DROP_MAX) ? DROP_MAX : m_drop + nd;
    endfunction

    task automatic model_check(input string tag);
        chk({tag, ".valid"}, int'(bus.ev_valid), int'(m_q.size() > 0));
        chk({tag, ".count"}, int'(bus.ev_count), m_q.size());
        chk({tag, ".drops"}, int'(bus.drop_count), m_drop);
        if (m_q.size() > 0) chk({tag, ".code"}, int'(bus.ev_code), m_q[0]);
    endtask

    // One clock: drive inputs after negedge, step model at posedge, return at negedge.
    task automatic cyc(input logic [4:0] cp, input bit push, evt, left, rdy, clr, r);
        bus.compass_pulse = cp; bus.rotary_push = push; bus.rotary_event = evt;
        bus.rotary_left = left; bus.ev_ready = rdy; bus.clr_drops = clr; rst = r;
        @(posedge clk);
        model_step(cp, push, evt, left, rdy, clr, r);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        cyc(5'd0, 0, 0, 0, rdy, 0, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] cp;
        bit push, evt, left, rdy, clr, r;
        bit chk_en;
        int valid, code, count, drop;
    } vec_t;
    vec_t tbl[$];

    function automatic void row(input logic [4:0] cp, input bit push, evt, left, rdy, clr, r,
                                input bit c, input int v, code, cnt, d);
        vec_t x;
        x.cp = cp; x.push = push; x.evt = evt; x.left = left; x.rdy = rdy; x.clr = clr; x.r = r;
        x.chk_en = c; x.valid = v; x.code = code; x.count = cnt; x.drop = d;
        tbl.push_back(x);
    endfunction

    initial begin
        int exp_all[7];
        int exp_drain[10];
        int codes[$];
        int pops;
        string nm;

        exp_all = '{0, 1, 2, 3, 4, 5, 7};
        exp_drain = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1};

        // Expected outputs are those seen during the row's cycle, before its edge.
        row(5'h00, 0,0,0, 0,0,1, 0, 0,0,0,0);   // reset
        row(5'h00, 0,0,0, 0,0,0, 1, 0,0,0,0);   // reset state
        row(5'h04, 0,0,0, 0,0,0, 1, 0,0,0,0);   // N pulse, cycle k
        row(5'h00, 0,0,0, 0,0,0, 1, 0,0,0,0);   // k+1: latched only
        row(5'h00, 0,0,0, 0,0,0, 1, 1,2,1,0);   // k+2: visible
        row(5'h00, 0,0,0, 1,0,0, 1, 1,2,1,0);   // pop
        row(5'h00, 0,0,0, 0,0,0, 1, 0,0,0,0);
        row(5'h00, 0,0,0, 0,0,1, 0, 0,0,0,0);   // reset
        row(5'h1f, 1,1,1, 0,0,0, 1, 0,0,0,0);   // all seven sources, left
        row(5'h00, 0,0,0, 0,0,0, 1, 0,0,0,0);
        for (int i = 1; i <= 7; i++) row(5'h00, 0,0,0, 0,0,0, 1, 1,0,i,0);
        for (int i = 0; i < 7; i++)  row(5'h00, 0,0,0, 1,0,0, 1, 1,exp_all[i],7-i,0);
        row(5'h00, 0,0,0, 0,0,0, 1, 0,0,0,0);

        bus.compass_pulse = '0; bus.rotary_push = 0; bus.rotary_event = 0;
        bus.rotary_left = 0; bus.ev_ready = 0; bus.clr_drops = 0; rst = 1;
        @(negedge clk);

        foreach (tbl[i]) begin
            if (tbl[i].chk_en) begin
                nm = $sformatf("vec%0d", i);
                chk({nm, ".valid"}, int'(bus.ev_valid), tbl[i].valid);
                chk({nm, ".count"}, int'(bus.ev_count), tbl[i].count);
                chk({nm, ".drops"}, int'(bus.drop_count), tbl[i].drop);
                if (tbl[i].valid != 0) chk({nm, ".code"}, int'(bus.ev_code), tbl[i].code);
            end
            $display("vec%0d: valid=%0d code=%0d count=%0d drops=%0d", i,
                     bus.ev_valid, bus.ev_code, bus.ev_count, bus.drop_count);
            cyc(tbl[i].cp, tbl[i].push, tbl[i].evt, tbl[i].left, tbl[i].rdy, tbl[i].clr, tbl[i].r);
        end

        // ---- full FIFO: fill with E, pending E and C, drops, clear ----
        cyc(5'h00, 0,0,0, 0,0,1);
        for (int n = 0; n < 9; n++) begin
            cyc(5'h02, 0,0,0, 0,0,0);
            idle(0);
        end
        idle(0); idle(0);
        chk("full.count", int'(bus.ev_count), 8);
        chk("full.valid", int'(bus.ev_valid), 1);
        chk("full.code", int'(bus.ev_code), 1);
        chk("full.drops0", int'(bus.drop_count), 0);
        cyc(5'h01, 0,0,0, 0,0,0); idle(0);           // C pending
        chk("full.c_pend_drops", int'(bus.drop_count), 0);
        cyc(5'h01, 0,0,0, 0,0,0); idle(0);           // second C dropped
        chk("full.c_drop", int'(bus.drop_count), 1);
        cyc(5'h02, 0,0,0, 0,0,0); idle(0);           // E dropped
        chk("full.e_drop", int'(bus.drop_count), 2);
        cyc(5'h02, 0,0,0, 0,1,0);                    // clear beats same-cycle drop
        chk("full.clr", int'(bus.drop_count), 0);
        chk("full.count_kept", int'(bus.ev_count), 8);
        pops = 0;
        for (int t = 0; t < 30; t++) begin
            if (bus.ev_valid) begin
                if (pops < 10) chk($sformatf("drain.code%0d", pops), int'(bus.ev_code), exp_drain[pops]);
                $display("drain pop %0d: code=%0d count=%0d", pops, bus.ev_code, bus.ev_count);
                pops++;
            end
            idle(1);
        end
        chk("drain.pops", pops, 10);
        chk("drain.empty", int'(bus.ev_count), 0);

        // ---- fairness: C and push re-pulse every cycle, drained each cycle ----
        cyc(5'h00, 0,0,0, 0,0,1);
        codes.delete();
        for (int t = 0; t < 14; t++) begin
            if (bus.ev_valid) begin
                codes.push_back(int'(bus.ev_code));
                $display("rr pop %0d: code=%0d", codes.size() - 1, bus.ev_code);
            end
            cyc(5'h01, 1,0,0, 1,0,0);
        end
        chk("rr.pops", codes.size(), 12);
        foreach (codes[i]) chk($sformatf("rr.code%0d", i), codes[i], (i % 2 == 0) ? 0 : 5);

        // ---- reset mid-operation ----
        cyc(5'h00, 0,0,0, 0,0,1);
        cyc(5'h1f, 0,0,0, 0,0,0);
        repeat (4) idle(0);
        chk("rst.pre_count", int'(bus.ev_count), 4);
        cyc(5'h02, 0,0,0, 0,0,1);                    // reset with a pulse present
        chk("rst.valid", int'(bus.ev_valid), 0);
        chk("rst.count", int'(bus.ev_count), 0);
        chk("rst.drops", int'(bus.drop_count), 0);
        chk("rst.code", int'(bus.ev_code), 0);
        repeat (3) idle(0);
        chk("rst.latches_clear", int'(bus.ev_valid), 0);
        cyc(5'h11, 0,0,0, 0,0,0);                    // C and W together
        idle(0);
        chk("rst.first_valid", int'(bus.ev_valid), 1);
        chk("rst.first_code", int'(bus.ev_code), 0);
        idle(0);
        chk("rst.second_count", int'(bus.ev_count), 2);
        idle(1);
        chk("rst.second_code", int'(bus.ev_code), 4);

        // ---- random: heavy load (drop saturation), then mixed traffic ----
        cyc(5'h00, 0,0,0, 0,0,1);
        for (int t = 0; t < 800; t++) begin
            model_check("rand_sat");
            cyc(5'(($urandom_range(99) < 40 ? 1 : 0) | ($urandom_range(99) < 40 ? 2 : 0) |
                   ($urandom_range(99) < 40 ? 4 : 0) | ($urandom_range(99) < 40 ? 8 : 0) |
                   ($urandom_range(99) < 40 ? 16 : 0)),
                $urandom_range(99) < 40, $urandom_range(99) < 40, $urandom_range(1) == 1,
                $urandom_range(99) < 10, 0, 0);
        end
        chk("rand_sat.saturated", int'(bus.drop_count), DROP_MAX);
        for (int t = 0; t < 2000; t++) begin
            model_check("rand_mix");
            cyc(5'($urandom_range(31) & $urandom_range(31)),
                $urandom_range(99) < 15, $urandom_range(99) < 15, $urandom_range(1) == 1,
                $urandom_range(99) < 60, $urandom_range(99) < 1, $urandom_range(999) < 3);
        end
        model_check("rand_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
